// File: rtl/wb_stage_pkg.sv
// Shared opcode codes and writeback FSM encodings for the writeback stage.
package wb_stage_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_NAND = 4'h2,
        OP_XOR  = 4'h3,
        OP_INC  = 4'h4,
        OP_SRA  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SLL  = 4'h7,
        OP_LW   = 4'h8,
        OP_SW   = 4'h9,
        OP_LHB  = 4'hA,
        OP_LLB  = 4'hB,
        OP_B    = 4'hC,
        OP_CALL = 4'hD,
        OP_RET  = 4'hE,
        OP_HLT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_MEM,
        HALT,
        HALTED
    } wb_state_t;

    // What an accepted instruction asks of the writeback stage.
    typedef enum logic [1:0] {
        WB_NONE,
        WB_REG,
        WB_LOAD,
        WB_STOP
    } wb_kind_t;

    localparam logic [3:0] LINK_REG = 4'd15;

endpackage

// File: rtl/wb_stage_sel.sv
// Per-opcode decode of writeback kind, destination register and write data.
module wb_stage_sel
    import wb_stage_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [3:0]  dst_addr,
    input  logic [15:0] result,
    output wb_kind_t    kind,
    output logic [3:0]  sel_addr,
    output logic [15:0] sel_data
);

    always_comb begin
        kind     = WB_NONE;
        sel_addr = dst_addr;
        sel_data = result;
        case (opcode_t'(opcode))
            OP_ADD, OP_SUB, OP_NAND, OP_XOR, OP_INC,
            OP_SRA, OP_SRL, OP_SLL, OP_LHB, OP_LLB: kind = WB_REG;
            // Link-register writes ignore the encoded destination field.
            OP_CALL, OP_RET: begin
                kind     = WB_REG;
                sel_addr = LINK_REG;
            end
            OP_LW:   kind = WB_LOAD;
            OP_HLT:  kind = WB_STOP;
            default: kind = WB_NONE;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registered register-file write port, load wait and halt sequencing.
// Define WB_STAGE_FWD_EN to add the fwd_* bypass ports for the ID stage.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [3:0]  in_dst_addr,
    input  logic [15:0] in_result,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [3:0]  dst_addr,
    output logic [15:0] dst,
    output logic        we,
    output logic        hlt,
    output logic        halted
`ifdef WB_STAGE_FWD_EN
    ,
    output logic        fwd_valid,
    output logic [3:0]  fwd_addr,
    output logic [15:0] fwd_data
`endif
);

    wb_state_t   state;
    wb_state_t   state_next;
    wb_kind_t    kind;
    logic [3:0]  sel_addr;
    logic [15:0] sel_data;
    logic [3:0]  addr_next;
    logic [15:0] data_next;
    logic        accept;

    wb_stage_sel u_sel (
        .opcode   (in_opcode),
        .dst_addr (in_dst_addr),
        .result   (in_result),
        .kind     (kind),
        .sel_addr (sel_addr),
        .sel_data (sel_data)
    );

    assign accept = in_valid && in_ready;

    // dst_addr doubles as the pending load destination while in WAIT_MEM.
    always_comb begin
        state_next = state;
        addr_next  = dst_addr;
        data_next  = dst;
        case (state)
            IDLE, WRITE: begin
                state_next = IDLE;
                if (accept) begin
                    case (kind)
                        WB_REG: begin
                            state_next = WRITE;
                            addr_next  = sel_addr;
                            data_next  = sel_data;
                        end
                        WB_LOAD: begin
                            state_next = WAIT_MEM;
                            addr_next  = sel_addr;
                        end
                        WB_STOP: state_next = HALT;
                        default: state_next = IDLE;
                    endcase
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_next = WRITE;
                    data_next  = mem_rdata;
                end
            end
            HALT:     state_next = HALTED;
            HALTED:   state_next = HALTED;
            default:  state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            we       <= 1'b0;
            dst_addr <= '0;
            dst      <= '0;
            hlt      <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == IDLE) || (state_next == WRITE);
            we       <= (state_next == WRITE) && (addr_next != 4'd0);
            dst_addr <= addr_next;
            dst      <= data_next;
            hlt      <= (state_next == HALT);
            halted   <= (state_next == HALTED);
        end
    end

`ifdef WB_STAGE_FWD_EN
    assign fwd_valid = we;
    assign fwd_addr  = dst_addr;
    assign fwd_data  = dst;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage with a small register-file sink model.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [3:0]  in_dst_addr;
    logic [15:0] in_result;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [3:0]  dst_addr;
    logic [15:0] dst;
    logic        we;
    logic        hlt;
    logic        halted;
`ifdef WB_STAGE_FWD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_addr;
    logic [15:0] fwd_data;
`endif

    logic [15:0] rf [16];
    int total = 0;
    int bad   = 0;

    wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_dst_addr (in_dst_addr),
        .in_result   (in_result),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .dst_addr    (dst_addr),
        .dst         (dst),
        .we          (we),
        .hlt         (hlt),
        .halted      (halted)
`ifdef WB_STAGE_FWD_EN
        ,
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    // Register file that the write port feeds; writes land on the edge after we is seen.
    always @(posedge clk) begin
        if (we) rf[dst_addr] <= dst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input opcode_t op, input logic [3:0] addr,
                                 input logic [15:0] res);
        in_valid    = v;
        in_opcode   = op;
        in_dst_addr = addr;
        in_result   = res;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_we"}, 16'(we), 16'd0);
        checkOutput({tag, "_ready"}, 16'(in_ready), 16'd1);
    endtask

    initial begin
        foreach (rf[i]) rf[i] = '0;
        rst        = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        applyStimulus(1'b0, OP_ADD, 4'd0, 16'h0);
        step();
        step();
        checkOutput("rst_we", 16'(we), 16'd0);
        checkOutput("rst_dst", dst, 16'h0);
        checkOutput("rst_addr", 16'(dst_addr), 16'd0);
        checkOutput("rst_hlt", 16'(hlt), 16'd0);
        checkOutput("rst_halted", 16'(halted), 16'd0);
        checkOutput("rst_ready", 16'(in_ready), 16'd1);
        rst = 1'b0;

        // Single ADD: write visible the cycle after acceptance.
        applyStimulus(1'b1, OP_ADD, 4'd1, 16'hABCD);
        step();
        applyStimulus(1'b0, OP_ADD, 4'd0, 16'h0);
        checkOutput("add_we", 16'(we), 16'd1);
        checkOutput("add_addr", 16'(dst_addr), 16'd1);
        checkOutput("add_dst", dst, 16'hABCD);
        step();
        checkOutput("add_rf1", rf[1], 16'hABCD);
        checkIdle("add_after");

        // Back-to-back SUB and XOR.
        applyStimulus(1'b1, OP_SUB, 4'd2, 16'hBEEF);
        step();
        checkOutput("sub_we", 16'(we), 16'd1);
        checkOutput("sub_dst", dst, 16'hBEEF);
        checkOutput("sub_addr", 16'(dst_addr), 16'd2);
        checkOutput("sub_ready", 16'(in_ready), 16'd1);
        applyStimulus(1'b1, OP_XOR, 4'd3, 16'hCAFE);
        step();
        applyStimulus(1'b0, OP_ADD, 4'd0, 16'h0);
        checkOutput("xor_we", 16'(we), 16'd1);
        checkOutput("xor_dst", dst, 16'hCAFE);
        checkOutput("xor_addr", 16'(dst_addr), 16'd3);
        checkOutput("xor_ready", 16'(in_ready), 16'd1);
        step();
        checkIdle("b2b_after");
        checkOutput("b2b_rf2", rf[2], 16'hBEEF);
        checkOutput("b2b_rf3", rf[3], 16'hCAFE);

        // LW with data after 3 cycles; an ADD offered while stalled must be dropped.
        applyStimulus(1'b1, OP_LW, 4'd4, 16'h0);
        step();
        applyStimulus(1'b1, OP_ADD, 4'd7, 16'h7777);
        checkOutput("lw_ready_c1", 16'(in_ready), 16'd0);
        checkOutput("lw_we_c1", 16'(we), 16'd0);
        step();
        checkOutput("lw_ready_c2", 16'(in_ready), 16'd0);
        applyStimulus(1'b0, OP_ADD, 4'd0, 16'h0);
        step();
        checkOutput("lw_ready_c3", 16'(in_ready), 16'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hB105;
        step();
        checkOutput("lw_we", 16'(we), 16'd1);
        checkOutput("lw_dst", dst, 16'hB105);
        checkOutput("lw_addr", 16'(dst_addr), 16'd4);
        checkOutput("lw_ready", 16'(in_ready), 16'd1);
        mem_rdata = 16'h5555;
        step();
        mem_rvalid = 1'b0;
        checkIdle("stray_rvalid");
        step();
        checkIdle("stray_rvalid2");
        checkOutput("lw_rf4", rf[4], 16'hB105);
        checkOutput("drop_rf7", rf[7], 16'h0);

        // CALL always targets R15.
        applyStimulus(1'b1, OP_CALL, 4'd5, 16'h10CB);
        step();
        applyStimulus(1'b0, OP_ADD, 4'd0, 16'h0);
        checkOutput("call_we", 16'(we), 16'd1);
        checkOutput("call_addr", 16'(dst_addr), 16'd15);
        checkOutput("call_dst", dst, 16'h10CB);
        step();
        checkOutput("call_rf15", rf[15], 16'h10CB);
        checkOutput("call_rf5", rf[5], 16'h0);

        // R0 write suppressed, then SW/B produce no write.
        applyStimulus(1'b1, OP_ADD, 4'd0, 16'h1234);
        step();
        checkIdle("r0");
        applyStimulus(1'b1, OP_SW, 4'd6, 16'h6666);
        step();
        checkIdle("sw");
        applyStimulus(1'b1, OP_B, 4'd6, 16'h6666);
        step();
        applyStimulus(1'b0, OP_ADD, 4'd0, 16'h0);
        checkIdle("b");
        step();
        checkOutput("r0_rf0", rf[0], 16'h0);
        checkOutput("sw_rf6", rf[6], 16'h0);

        // ADD then HLT back-to-back.
        applyStimulus(1'b1, OP_ADD, 4'd8, 16'h0808);
        step();
        checkOutput("hadd_we", 16'(we), 16'd1);
        applyStimulus(1'b1, OP_HLT, 4'd0, 16'h0);
        step();
        applyStimulus(1'b0, OP_ADD, 4'd0, 16'h0);
        checkOutput("hlt_pulse", 16'(hlt), 16'd1);
        checkOutput("hlt_we", 16'(we), 16'd0);
        checkOutput("hlt_ready", 16'(in_ready), 16'd0);
        checkOutput("hlt_halted", 16'(halted), 16'd0);
        checkOutput("hlt_rf8", rf[8], 16'h0808);
        applyStimulus(1'b1, OP_ADD, 4'd9, 16'h0909);
        step();
        checkOutput("halted_hlt", 16'(hlt), 16'd0);
        checkOutput("halted_lvl", 16'(halted), 16'd1);
        checkOutput("halted_ready", 16'(in_ready), 16'd0);
        step();
        step();
        checkOutput("halted_hold", 16'(halted), 16'd1);
        checkOutput("halted_we", 16'(we), 16'd0);
        checkOutput("halted_rf9", rf[9], 16'h0);
        applyStimulus(1'b0, OP_ADD, 4'd0, 16'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("unhalt_halted", 16'(halted), 16'd0);
        checkIdle("unhalt");

        // Reset during WAIT_MEM abandons the load.
        applyStimulus(1'b1, OP_LW, 4'd10, 16'h0);
        step();
        applyStimulus(1'b0, OP_ADD, 4'd0, 16'h0);
        checkOutput("lwr_ready", 16'(in_ready), 16'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkIdle("lwr_rst");
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        step();
        mem_rvalid = 1'b0;
        checkIdle("lwr_rvalid");
        step();
        checkOutput("lwr_rf10", rf[10], 16'h0);

        // Reset wins over a simultaneous accept.
        rst = 1'b1;
        applyStimulus(1'b1, OP_ADD, 4'd11, 16'h1111);
        step();
        rst = 1'b0;
        applyStimulus(1'b0, OP_ADD, 4'd0, 16'h0);
        checkIdle("rstpri");
        step();
        checkOutput("rstpri_rf11", rf[11], 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: in_valid  in  1  upstream (EX/MEM) result valid.
REQ-004 SHALL have: in_ready  out  1  stage accepts a result this cycle.
REQ-005 SHALL have: in_opcode  in  4  opcode.h code of the retiring instruction.
REQ-006 SHALL have: in_dst_addr  in  4  destination register; in_result  in  16  ALU result.
REQ-007 SHALL have: mem_rdata  in  16  load data; mem_rvalid  in  1  load data valid (one-cycle pulse).
REQ-008 SHALL have: dst_addr  out  4; dst  out  16; we  out  1  register-file write port.
REQ-009 SHALL have: hlt  out  1  halt pulse to register file; halted  out  1  level, stage stopped.
REQ-010 SHALL have (WB_FWD_EN only): fwd_valid  out  1; fwd_addr  out  4; fwd_data  out  16.

Function
REQ-011 SHALL accept a result on a rising edge where in_valid && in_ready.
REQ-012 SHALL use FSM states IDLE, WRITE, WAIT_MEM, HALT, HALTED.
REQ-013 IDLE: in_ready=1; accepted ADD/SUB/NAND/XOR/INC/SRA/SRL/SLL/LHB/LLB/CALL/RET -> WRITE; LW -> WAIT_MEM; SW/B -> IDLE, no write; HLT -> HALT.
REQ-014 WRITE: we=1 for exactly one cycle with registered dst_addr/dst; in_ready=1, so a back-to-back accept sets the next state per REQ-013 (sustained one result/cycle).
REQ-015 Write latency SHALL be one cycle: accept at edge N -> we high in cycle N+1 -> register file writes at edge N+2.
REQ-016 CALL and RET SHALL write in_result to R15 regardless of in_dst_addr.
REQ-017 WAIT_MEM: in_ready=0; on mem_rvalid, capture mem_rdata -> WRITE; mem_rvalid in any other state is ignored.
REQ-018 Writes to R0 SHALL be suppressed (we stays 0), while FSM timing is unchanged.
REQ-019 HALT: when no write pending, pulse hlt=1 for one cycle -> HALTED; pending write completes first.
REQ-020 HALTED: in_ready=0, we=0, halted=1, held until rst.
REQ-021 in_valid with in_ready=0 SHALL be ignored; upstream holds the result.
REQ-022 All outputs SHALL be registered; no combinational path from inputs to we/dst.

Reset
REQ-023 rst SHALL force IDLE, in_ready=1 in the following cycle, we=0, dst=0, dst_addr=0, hlt=0, halted=0, fwd_valid=0.
REQ-024 rst during WAIT_MEM or HALT SHALL abandon the pending write/halt; later mem_rvalid is ignored.
REQ-025 rst SHALL take priority over a simultaneous accept.

Configuration
REQ-026 Macro WB_STAGE_FWD_EN defined: fwd_* ports exist and mirror we/dst_addr/dst in the same cycle, for ID-stage bypass.
REQ-027 Macro undefined: fwd_* ports and logic SHALL be absent; other behaviour identical.

Structure
REQ-028 Opcode codes SHALL come from shared opcode.h; FSM state encodings SHALL go in a shared wb_pkg header.
REQ-029 One sub-module wb_sel (combinational write-data/address select per opcode) is natural; FSM stays in wb_stage.

Verification
REQ-030 Reset, then ADD dst=R1 result=16'hABCD -> next cycle we=1, dst_addr=1, dst=16'hABCD; R1 reads 16'hABCD.
REQ-031 Back-to-back SUB R2=16'hBEEF, XOR R3=16'hCAFE -> we high in two consecutive cycles, in_ready never low.
REQ-032 LW dst=R4, mem_rvalid after 3 cycles with 16'hB105 -> in_ready=0 for 3 cycles, then we=1, dst=16'hB105.
REQ-033 CALL with in_dst_addr=5, result=16'h10CB -> write to R15=16'h10CB; write to R0 -> we stays 0.
REQ-034 ADD then HLT -> ADD write, then hlt pulse of one cycle, halted=1, in_ready=0 until rst.
REQ-035 rst asserted in WAIT_MEM, then mem_rvalid -> no write; in_ready=1 the cycle after rst.
